lcd_cmd_scheduler: RTL and testbench

Sequencer between the PS/2→ASCII key path and the HD44780 LCD driver.
It buffers decoded key codes in a small FIFO, tracks the 2x16 cursor, and expands each key into LCD command/data transfers: DDRAM address sets, character writes, backspace erase, newline and clear.
It issues the LCD power-up init sequence after reset.
It owns the start/busy handshake with the LCD driver.

---
 rtl/lcd_cmd_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_cmd_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_scheduler.sv
// Key-to-LCD command sequencer: queues ASCII keys, tracks the 2x16 cursor and
// expands each key into HD44780 transfers after running the power-up init.
module lcd_cmd_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int COLS       = 16
) (
   input  logic       CLK50MHz,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   input  logic       lcd_busy,
   output logic       lcd_start,
   output logic       lcd_rs,
   output logic [7:0] lcd_cmd,
   output logic       cursor_row,
   output logic [3:0] cursor_col,
   output logic       fifo_full,
   output logic       overflow,
   output logic       idle
);

   // state      | meaning
   // S_INIT     | load the power-up init sequence
   // S_IDLE     | wait for a queued key
   // S_DISPATCH | pop a key and build its transfer list
   // S_ISSUE    | pulse lcd_start once the driver is free
   // S_WAIT_HI  | wait for the driver to raise busy
   // S_WAIT_LO  | wait for busy to fall, then next transfer or done
   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_DISPATCH, S_ISSUE, S_WAIT_HI, S_WAIT_LO
   } state_t;

   localparam int AW = $clog2(FIFO_DEPTH);

   state_t           state_q, state_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       seq_cmd_q [4];
   logic [7:0]       seq_cmd_d [4];
   logic [3:0]       seq_rs_q, seq_rs_d;
   logic [1:0]       seq_last_q, seq_last_d, idx_q, idx_d;
   logic             tgt_row_q, tgt_row_d, row_q, row_d;
   logic [3:0]       tgt_col_q, tgt_col_d, col_q, col_d;
   logic [7:0]       cmd_q, cmd_d;
   logic             rs_q, rs_d;

   logic             empty, full, push, pop;
   logic [7:0]       head;
   logic             bs_row;
   logic [3:0]       bs_col;

   function automatic logic [7:0] set_addr(input logic r, input logic [3:0] c);
      return {1'b1, r, 2'b00, c};
   endfunction

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // Backspace target: col 0 of row 1 steps back to the end of row 0.
   assign bs_row = (col_q == 4'd0) ? 1'b0 : row_q;
   assign bs_col = (col_q == 4'd0) ? 4'(COLS - 1) : col_q - 4'd1;

   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      seq_cmd_d  = seq_cmd_q;
      seq_rs_d   = seq_rs_q;
      seq_last_d = seq_last_q;
      idx_d      = idx_q;
      tgt_row_d  = tgt_row_q;
      tgt_col_d  = tgt_col_q;
      row_d      = row_q;
      col_d      = col_q;
      cmd_d      = cmd_q;
      rs_d       = rs_q;
      lcd_start  = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_INIT: begin
            seq_cmd_d  = '{8'h38, 8'h0C, 8'h06, 8'h01};
            seq_rs_d   = 4'b0000;
            seq_last_d = 2'd3;
            idx_d      = 2'd0;
            tgt_row_d  = 1'b0;
            tgt_col_d  = 4'd0;
            state_d    = S_ISSUE;
         end
         S_IDLE: begin
            if (!empty) state_d = S_DISPATCH;
         end
         S_DISPATCH: begin
            pop     = 1'b1;
            idx_d   = 2'd0;
            state_d = S_IDLE;
            if (head >= 8'h20 && head <= 8'h7E) begin
               seq_cmd_d[0] = head;
               seq_rs_d[0]  = 1'b1;
               state_d      = S_ISSUE;
               if (col_q == 4'(COLS - 1)) begin
                  tgt_row_d    = ~row_q;
                  tgt_col_d    = 4'd0;
                  seq_cmd_d[1] = set_addr(~row_q, 4'd0);
                  seq_rs_d[1]  = 1'b0;
                  seq_last_d   = 2'd1;
               end else begin
                  tgt_row_d  = row_q;
                  tgt_col_d  = col_q + 4'd1;
                  seq_last_d = 2'd0;
               end
            end else if (head == 8'h0D) begin
               tgt_row_d    = ~row_q;
               tgt_col_d    = 4'd0;
               seq_cmd_d[0] = set_addr(~row_q, 4'd0);
               seq_rs_d[0]  = 1'b0;
               seq_last_d   = 2'd0;
               state_d      = S_ISSUE;
            end else if (head == 8'h08) begin
               if (row_q || col_q != 4'd0) begin
                  tgt_row_d    = bs_row;
                  tgt_col_d    = bs_col;
                  seq_cmd_d[0] = set_addr(bs_row, bs_col);
                  seq_cmd_d[1] = 8'h20;
                  seq_cmd_d[2] = set_addr(bs_row, bs_col);
                  seq_rs_d     = 4'b0010;
                  seq_last_d   = 2'd2;
                  state_d      = S_ISSUE;
               end
            end else if (head == 8'h1B) begin
               tgt_row_d    = 1'b0;
               tgt_col_d    = 4'd0;
               seq_cmd_d[0] = 8'h01;
               seq_rs_d[0]  = 1'b0;
               seq_last_d   = 2'd0;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!lcd_busy) begin
               lcd_start = 1'b1;
               state_d   = S_WAIT_HI;
               if (idx_q == seq_last_q) begin
                  row_d = tgt_row_q;
                  col_d = tgt_col_q;
               end
            end
         end
         S_WAIT_HI: begin
            if (lcd_busy) state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!lcd_busy) begin
               if (idx_q == seq_last_q) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_INIT;
      endcase

      // The byte is latched on entry to ISSUE so it is already valid with the start pulse.
      if (state_d == S_ISSUE && state_q != S_ISSUE) begin
         cmd_d = seq_cmd_d[idx_d];
         rs_d  = seq_rs_d[idx_d];
      end

      push = key_valid && (!full || pop);
      if (key_valid && full && !pop) overflow_d = 1'b1;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = key_code;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge CLK50MHz or posedge reset) begin
      if (reset) begin
         state_q    <= S_INIT;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         seq_cmd_q  <= '{default: '0};
         seq_rs_q   <= '0;
         seq_last_q <= '0;
         idx_q      <= '0;
         tgt_row_q  <= 1'b0;
         tgt_col_q  <= '0;
         row_q      <= 1'b0;
         col_q      <= '0;
         cmd_q      <= '0;
         rs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         seq_cmd_q  <= seq_cmd_d;
         seq_rs_q   <= seq_rs_d;
         seq_last_q <= seq_last_d;
         idx_q      <= idx_d;
         tgt_row_q  <= tgt_row_d;
         tgt_col_q  <= tgt_col_d;
         row_q      <= row_d;
         col_q      <= col_d;
         cmd_q      <= cmd_d;
         rs_q       <= rs_d;
      end
   end

   assign lcd_cmd    = cmd_q;
   assign lcd_rs     = rs_q;
   assign cursor_row = row_q;
   assign cursor_col = col_q;
   assign fifo_full  = full;
   assign overflow   = overflow_q;
   assign idle       = (state_q == S_IDLE) && empty && !lcd_busy;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler with a 5-cycle busy LCD driver model.
module tb_lcd_cmd_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_valid;
   logic [7:0] key_code;
   logic       lcd_busy;
   logic       lcd_start, lcd_rs;
   logic [7:0] lcd_cmd;
   logic       cursor_row;
   logic [3:0] cursor_col;
   logic       fifo_full, overflow, idle;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         busy_cnt;
   logic       force_busy;
   logic [8:0] xfer_log [$];

   lcd_cmd_scheduler #(.FIFO_DEPTH(4), .COLS(16)) dut (
      .CLK50MHz  (clk),
      .reset     (reset),
      .key_valid (key_valid),
      .key_code  (key_code),
      .lcd_busy  (lcd_busy),
      .lcd_start (lcd_start),
      .lcd_rs    (lcd_rs),
      .lcd_cmd   (lcd_cmd),
      .cursor_row(cursor_row),
      .cursor_col(cursor_col),
      .fifo_full (fifo_full),
      .overflow  (overflow),
      .idle      (idle)
   );

   always #10 clk = ~clk;

   // Driver model: busy for 5 cycles after every start.
   always @(posedge clk or posedge reset) begin
      if (reset)          busy_cnt <= 0;
      else if (lcd_start) busy_cnt <= 5;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign lcd_busy = force_busy || (busy_cnt != 0);

   always @(negedge clk) if (lcd_start) xfer_log.push_back({lcd_rs, lcd_cmd});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_key(input logic [7:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!idle && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 32'(idle), 32'd1);
   endtask

   task automatic check_xfer(input string tag, input int i, input logic [8:0] exp);
      if (i < xfer_log.size()) check(tag, 32'(xfer_log[i]), 32'(exp));
      else check({tag, "_missing"}, 32'(xfer_log.size()), 32'(i + 1));
   endtask

   initial begin
      logic [7:0] init_seq [4];
      int n;
      init_seq   = '{8'h38, 8'h0C, 8'h06, 8'h01};
      reset      = 1'b1;
      key_valid  = 1'b0;
      key_code   = 8'h00;
      force_busy = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_start", 32'(lcd_start), 0);
      check("rst_rs", 32'(lcd_rs), 0);
      check("rst_cmd", 32'(lcd_cmd), 0);
      check("rst_row", 32'(cursor_row), 0);
      check("rst_col", 32'(cursor_col), 0);
      check("rst_full", 32'(fifo_full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_idle", 32'(idle), 0);

      // Init sequence
      reset = 1'b0;
      wait_idle("init");
      check("init_count", 32'(xfer_log.size()), 4);
      for (int i = 0; i < 4; i++) check_xfer("init_cmd", i, {1'b0, init_seq[i]});

      // Single printable character
      xfer_log.delete();
      push_key(8'h41);
      wait_idle("char");
      check("char_count", 32'(xfer_log.size()), 1);
      check_xfer("char_xfer", 0, 9'h141);
      check("char_row", 32'(cursor_row), 0);
      check("char_col", 32'(cursor_col), 1);

      // Clear, then a full line wraps onto row 1
      xfer_log.delete();
      push_key(8'h1B);
      wait_idle("clr");
      check_xfer("clr_xfer", 0, 9'h001);
      check("clr_col", 32'(cursor_col), 0);
      xfer_log.delete();
      for (int i = 0; i < 16; i++) begin
         push_key(8'h41);
         wait_idle("line");
      end
      check("wrap_count", 32'(xfer_log.size()), 17);
      check_xfer("wrap_first", 0, 9'h141);
      check_xfer("wrap_last_data", 15, 9'h141);
      check_xfer("wrap_addr", 16, 9'h0C0);
      check("wrap_row", 32'(cursor_row), 1);
      check("wrap_col", 32'(cursor_col), 0);

      // Backspace across the line boundary
      xfer_log.delete();
      push_key(8'h08);
      wait_idle("bs");
      check("bs_count", 32'(xfer_log.size()), 3);
      check_xfer("bs_addr0", 0, 9'h08F);
      check_xfer("bs_space", 1, 9'h120);
      check_xfer("bs_addr1", 2, 9'h08F);
      check("bs_row", 32'(cursor_row), 0);
      check("bs_col", 32'(cursor_col), 15);

      // Backspace at home and an ignored code: no transfers
      push_key(8'h1B);
      wait_idle("clr2");
      xfer_log.delete();
      push_key(8'h08);
      wait_idle("bs_home");
      push_key(8'h07);
      wait_idle("ignored");
      repeat (5) @(negedge clk);
      check("bs_home_none", 32'(xfer_log.size()), 0);
      check("bs_home_col", 32'(cursor_col), 0);

      // Enter
      push_key(8'h0D);
      wait_idle("enter");
      check("enter_count", 32'(xfer_log.size()), 1);
      check_xfer("enter_addr", 0, 9'h0C0);
      check("enter_row", 32'(cursor_row), 1);

      // Overflow: one key in flight plus four queued, the sixth is dropped
      xfer_log.delete();
      force_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         key_valid = 1'b1;
         key_code  = 8'h61 + 8'(i);
      end
      @(negedge clk);
      key_valid = 1'b0;
      check("ovf_full", 32'(fifo_full), 1);
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_nostart", 32'(xfer_log.size()), 0);
      force_busy = 1'b0;
      wait_idle("ovf");
      check("ovf_count", 32'(xfer_log.size()), 5);
      for (int i = 0; i < 5; i++) check_xfer("ovf_order", i, {1'b1, 8'h61 + 8'(i)});
      check("ovf_col", 32'(cursor_col), 5);
      check("ovf_sticky", 32'(overflow), 1);

      // Reset in the middle of a backspace
      xfer_log.delete();
      push_key(8'h08);
      n = 0;
      while (xfer_log.size() < 1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("midbs_started", 32'(xfer_log.size()), 1);
      push_key(8'h41);
      push_key(8'h42);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_cmd", 32'(lcd_cmd), 0);
      check("mid_rst_start", 32'(lcd_start), 0);
      check("mid_rst_row", 32'(cursor_row), 0);
      check("mid_rst_col", 32'(cursor_col), 0);
      check("mid_rst_ovf", 32'(overflow), 0);
      check("mid_rst_full", 32'(fifo_full), 0);
      check("mid_rst_idle", 32'(idle), 0);
      @(negedge clk);
      xfer_log.delete();
      reset = 1'b0;
      wait_idle("reinit");
      repeat (20) @(negedge clk);
      check("reinit_count", 32'(xfer_log.size()), 4);
      for (int i = 0; i < 4; i++) check_xfer("reinit_cmd", i, {1'b0, init_seq[i]});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
